// File: rtl/down_counter_ctrl.sv
// Sequencer for a down counter: loads a start value, issues prescaled
// decrement strobes until the counter reports zero, then pulses done.
module down_counter_ctrl #(
   parameter int unsigned WIDTH    = 4,
   parameter int unsigned PRESCALE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             hold,
   input  logic             abort,
   input  logic             zero,
   output logic [WIDTH-1:0] IN,
   output logic             latch,
   output logic             dec,
   output logic             busy,
   output logic             done
);

   localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_COUNT = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [PCNT_W-1:0]   pcnt;
   logic [PCNT_W-1:0]   pcnt_nxt;
   logic [WIDTH-1:0]    in_nxt;
   logic                tick;

   assign tick = (pcnt == PCNT_W'(PRESCALE - 1));

   // State, captured load value and prescale counter
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         IN    <= '0;
         pcnt  <= '0;
      end else begin
         state <= state_nxt;
         IN    <= in_nxt;
         pcnt  <= pcnt_nxt;
      end
   end

   // Next state and strobes; dec stays combinational on zero so no
   // decrement is ever issued once the counter has reached zero.
   always_comb begin
      state_nxt = state;
      pcnt_nxt  = pcnt;
      in_nxt    = IN;
      latch     = 1'b0;
      dec       = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               in_nxt    = load_val;
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            latch     = 1'b1;
            busy      = 1'b1;
            pcnt_nxt  = '0;
            state_nxt = abort ? S_IDLE : S_COUNT;
         end
         S_COUNT: begin
            busy = 1'b1;
            if (abort) begin
               state_nxt = S_IDLE;
            end else begin
               dec = tick & ~hold & ~zero;
               if (!hold) begin
                  pcnt_nxt = tick ? '0 : pcnt + PCNT_W'(1);
               end
               if (zero) begin
                  state_nxt = S_DONE;
               end
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule
